// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcodes, FSM states and helpers shared by seq_alu and its mul/div engine
package seq_alu_pkg;
  localparam int OPW = 4;
  localparam logic [OPW-1:0] OP_AND   = 4'b0000;
  localparam logic [OPW-1:0] OP_OR    = 4'b0001;
  localparam logic [OPW-1:0] OP_ADD   = 4'b0010;
  localparam logic [OPW-1:0] OP_XOR   = 4'b0011;
  localparam logic [OPW-1:0] OP_SLL   = 4'b0100;
  localparam logic [OPW-1:0] OP_SRL   = 4'b0101;
  localparam logic [OPW-1:0] OP_SUB   = 4'b0110;
  localparam logic [OPW-1:0] OP_SLTU  = 4'b0111;
  localparam logic [OPW-1:0] OP_SLT   = 4'b1000;
  localparam logic [OPW-1:0] OP_MUL   = 4'b1001;
  localparam logic [OPW-1:0] OP_MULHU = 4'b1010;
  localparam logic [OPW-1:0] OP_DIVU  = 4'b1011;
  localparam logic [OPW-1:0] OP_NOR   = 4'b1100;
  localparam logic [OPW-1:0] OP_SRA   = 4'b1101;
  localparam logic [OPW-1:0] OP_REMU  = 4'b1110;
  localparam logic [OPW-1:0] OP_RSV   = 4'b1111;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
  function automatic logic is_multicycle(input logic [OPW-1:0] op);
    return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
  endfunction
endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative shift-add multiplier / restoring divider, one bit per cycle
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);
  localparam int CW = $clog2(XLEN);
  logic [2*XLEN-1:0] acc, acc_d;
  logic [XLEN-1:0] b_q;
  logic [OPW-1:0] op_q;
  logic [CW-1:0] cnt;
  logic run, is_div;
  logic [XLEN:0] sum, trial, diff;
  // acc holds {accumulator, multiplier} for mul and {remainder, dividend/quotient} for div
  always_comb begin
    is_div = op_q == OP_DIVU || op_q == OP_REMU;
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
    trial = acc[2*XLEN-1:XLEN-1];
    diff = trial - {1'b0, b_q};
    acc_d = !is_div ? {sum, acc[XLEN-1:1]} :
            diff[XLEN] ? {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0} :
                         {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end
  assign done = run && cnt == '0;
  assign res = (op_q == OP_MUL || op_q == OP_DIVU) ? acc_d[XLEN-1:0] : acc_d[2*XLEN-1:XLEN];
  always_ff @(posedge clk)
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
      acc <= '0;
      b_q <= '0;
      op_q <= OP_AND;
    end else if (flush) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= CW'(XLEN - 1);
      acc <= {{XLEN{1'b0}}, a};
      b_q <= b;
      op_q <= op;
    end else if (run) begin
      acc <= acc_d;
      cnt <= cnt - CW'(1);
      run <= cnt != '0;
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle execute-stage ALU with valid/ready handshake; SEQ_ALU_MULDIV_EN enables iterative mul/div
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW = seq_alu_pkg::OPW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  input  logic [OPW-1:0]  alu_op,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);
  state_t state, state_d;
  logic accept, start, md_done, wr;
  logic [XLEN-1:0] alu_res, md_res, wr_res;
  logic [SHW-1:0] sh;
  assign sh = r2[SHW-1:0];
  assign in_ready = state == ST_IDLE;
  assign out_valid = state == ST_DONE;
  assign accept = in_valid && in_ready && !flush;
`ifdef SEQ_ALU_MULDIV_EN
  // divide by zero resolves in the single-cycle path
  assign start = accept && is_multicycle(alu_op) &&
                 !((alu_op == OP_DIVU || alu_op == OP_REMU) && r2 == '0);
  assign busy = state == ST_BUSY;
  seq_alu_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .start(start),
    .op(alu_op),
    .a(r1),
    .b(r2),
    .done(md_done),
    .res(md_res)
  );
`else
  assign start = 1'b0;
  assign busy = 1'b0;
  assign md_done = 1'b0;
  assign md_res = '0;
`endif
  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_AND:  alu_res = r1 & r2;
      OP_OR:   alu_res = r1 | r2;
      OP_ADD:  alu_res = r1 + r2;
      OP_XOR:  alu_res = r1 ^ r2;
      OP_SLL:  alu_res = r1 << sh;
      OP_SRL:  alu_res = r1 >> sh;
      OP_SUB:  alu_res = r1 - r2;
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, r1 < r2};
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(r1) < $signed(r2)};
      OP_NOR:  alu_res = ~(r1 | r2);
      OP_SRA:  alu_res = $signed(r1) >>> sh;
`ifdef SEQ_ALU_MULDIV_EN
      OP_DIVU: alu_res = '1;
      OP_REMU: alu_res = r1;
`endif
      default: alu_res = '0;
    endcase
  end
  always_comb begin
    state_d = state;
    if (flush) state_d = ST_IDLE;
    else
      case (state)
        ST_IDLE: if (in_valid) state_d = start ? ST_BUSY : ST_DONE;
`ifdef SEQ_ALU_MULDIV_EN
        ST_BUSY: if (md_done) state_d = ST_DONE;
`endif
        ST_DONE: if (out_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_d;
  assign wr = (accept && !start) || (md_done && !flush);
  assign wr_res = accept ? alu_res : md_res;
  always_ff @(posedge clk)
    if (!rst_n) begin
      result <= '0;
      zero <= 1'b1;
    end else if (wr) begin
      result <= wr_res;
      zero <= wr_res == '0;
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors against a transaction-level model of seq_alu (honours SEQ_ALU_MULDIV_EN)
module tb_seq_alu;
  import seq_alu_pkg::*;
`ifdef SEQ_ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, zero, busy;
  logic [31:0] r1 = '0, r2 = '0, result;
  logic [3:0] alu_op = '0;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0, act = 1'b0;
  int cyc = 0, exp_lat = 1;
  logic [31:0] exp_res = '0;

  seq_alu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .r1(r1), .r2(r2), .alu_op(alu_op), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_ADD:   return a + b;
      OP_XOR:   return a ^ b;
      OP_SLL:   return a << b[4:0];
      OP_SRL:   return a >> b[4:0];
      OP_SUB:   return a - b;
      OP_SLTU:  return {31'b0, a < b};
      OP_SLT:   return {31'b0, $signed(a) < $signed(b)};
      OP_NOR:   return ~(a | b);
      OP_SRA:   return $signed(a) >>> b[4:0];
      OP_MUL:   return MD_EN ? p[31:0] : '0;
      OP_MULHU: return MD_EN ? p[63:32] : '0;
      OP_DIVU:  return !MD_EN ? '0 : b == 0 ? '1 : a / b;
      OP_REMU:  return !MD_EN ? '0 : b == 0 ? a : a % b;
      default:  return '0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
    bit long_op;
    long_op = MD_EN && (op == OP_MUL || op == OP_MULHU ||
              ((op == OP_DIVU || op == OP_REMU) && b != 0));
    return long_op ? 33 : 1;
  endfunction

  // transaction model: one op held from accept until released, flush/reset drop it
  always @(posedge clk) begin
    if (!rst_n || flush) act = 1'b0;
    else if (!act) begin
      if (in_valid) begin
        act = 1'b1;
        cyc = 1;
        exp_res = ref_res(alu_op, r1, r2);
        exp_lat = ref_lat(alu_op, r2);
      end
    end else if (cyc >= exp_lat && out_ready) act = 1'b0;
    else cyc++;
  end

  always @(negedge clk)
    if (chk_en) begin
      automatic bit ev = act && cyc >= exp_lat;
      chk("in_ready", 32'(in_ready), 32'(!act));
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(act && !ev));
      if (ev) begin
        chk("result", result, exp_res);
        chk("zero", 32'(zero), 32'(exp_res == 0));
      end
    end

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input int lat_exp);
    int lat;
    out_ready = 1'b1;
    alu_op = op; r1 = a; r2 = b; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0; r1 = $urandom; r2 = $urandom; alu_op = 4'($urandom_range(0, 15));
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #2;
      lat++;
    end
    chk("lit_lat", 32'(lat), 32'(lat_exp));
    chk("lit_res", result, lit);
    chk("lit_zero", 32'(zero), 32'(lit == 0));
    @(posedge clk); #2;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_result", result, 32'h0);
    chk("rst_zero", 32'(zero), 32'h1);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_valid", 32'(out_valid), 32'h0);

    run_op(OP_ADD, 5, 7, 12, 1);
    run_op(OP_SUB, 9, 9, 0, 1);
    run_op(OP_SLT, 32'hFFFFFFFF, 1, 1, 1);
    run_op(OP_SLTU, 32'hFFFFFFFF, 1, 0, 1);
    run_op(OP_SRA, 32'h80000000, 4, 32'hF8000000, 1);
    run_op(OP_SLL, 1, 33, 2, 1);
    run_op(OP_SRL, 32'h80, 3, 32'h10, 1);
    run_op(OP_AND, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1);
    run_op(OP_OR, 32'hF0, 32'h0F, 32'hFF, 1);
    run_op(OP_NOR, 0, 0, 32'hFFFFFFFF, 1);
    run_op(OP_ADD, 32'hFFFFFFFF, 1, 0, 1);
    run_op(OP_RSV, 32'h1234, 32'h5678, 0, 1);
`ifdef SEQ_ALU_MULDIV_EN
    run_op(OP_MUL, 32'h10000, 32'h10000, 0, 33);
    run_op(OP_MULHU, 32'h10000, 32'h10000, 1, 33);
    run_op(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 33);
    run_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op(OP_DIVU, 100, 7, 14, 33);
    run_op(OP_REMU, 100, 7, 2, 33);
    run_op(OP_DIVU, 5, 0, 32'hFFFFFFFF, 1);
    run_op(OP_REMU, 100, 0, 100, 1);
`else
    run_op(OP_MUL, 32'h10000, 32'h10000, 0, 1);
    run_op(OP_MULHU, 32'h10000, 32'h10000, 0, 1);
    run_op(OP_DIVU, 100, 7, 0, 1);
    run_op(OP_REMU, 100, 7, 0, 1);
`endif

    // backpressure: result held, pending request not accepted until after release
    out_ready = 1'b0;
    alu_op = OP_XOR; r1 = 32'hF0F0; r2 = 32'hFF00; in_valid = 1'b1;
    @(posedge clk); #2;
    alu_op = OP_ADD; r1 = 1; r2 = 2;
    repeat (5) begin
      @(posedge clk); #2;
      chk("bp_res", result, 32'h0FF0);
      chk("bp_zero", 32'(zero), 32'h0);
      chk("bp_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_release_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(out_valid), 32'h1);
    chk("bp_next_res", result, 32'h3);
    @(posedge clk); #2;

    // flush while holding a result
    out_ready = 1'b0;
    alu_op = OP_AND; r1 = 32'hFF; r2 = 32'h0F; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    out_ready = 1'b1;
    chk("flush_done_valid", 32'(out_valid), 32'h0);
    chk("flush_done_ready", 32'(in_ready), 32'h1);

    // flush beats a request in IDLE
    alu_op = OP_ADD; r1 = 1; r2 = 1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #2;
    chk("flush_idle_valid2", 32'(out_valid), 32'h0);

`ifdef SEQ_ALU_MULDIV_EN
    alu_op = OP_DIVU; r1 = 100; r2 = 7; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    chk("flush_div_busy", 32'(busy), 32'h0);
    chk("flush_div_ready", 32'(in_ready), 32'h1);
    repeat (30) @(posedge clk);
    #2 run_op(OP_DIVU, 1000, 10, 100, 33);
    alu_op = OP_MUL; r1 = 3; r2 = 5;
`else
    alu_op = OP_ADD; r1 = 3; r2 = 5;
`endif
    // reset in the middle of an operation
    out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); #2;
    chk("rst_mid_valid", 32'(out_valid), 32'h0);
    chk("rst_mid_result", result, 32'h0);
    chk("rst_mid_zero", 32'(zero), 32'h1);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #2;
    chk("rst_mid_ready", 32'(in_ready), 32'h1);
    run_op(OP_ADD, 32'h7FFFFFFF, 1, 32'h80000000, 1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Keeps the existing 4-bit opcode set and zero flag, adds shifts, XOR and signed compare, and adds iterative RV32M-style multiply/divide.
- Uses a valid/ready handshake on both sides and sits between decode/operand-read and writeback in the execute stage.
- Holds one operation at a time. The core stalls on in_ready.

Parameters:
- XLEN, 32, operand/result width in bits (>=8, power of two).
- OPW, 4, opcode width (fixed at 4; exposed for the package).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- r1  in  XLEN  operand A.
- r2  in  XLEN  operand B.
- alu_op  in  OPW  opcode.
- flush  in  1  abort any in-flight op and drop a held result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  registered result.
- zero  out  1  registered, result == 0.
- busy  out  1  multi-cycle op in progress.

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - 0111 SLTU (unsigned, as today), 1100 NOR.
  - New: 0011 XOR, 0100 SLL, 0101 SRL, 1101 SRA, 1000 SLT (signed).
  - New multiply/divide: 1001 MUL (low XLEN), 1010 MULHU (high XLEN, unsigned), 1011 DIVU, 1110 REMU.
  - 1111: reserved, result 0.
- Shift amount = r2[log2(XLEN)-1:0]. Add/sub wrap modulo 2^XLEN; no overflow flag.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - Handshake fires when in_valid && in_ready; operands and opcode are latched on that edge.
- IDLE -> DONE: taken for single-cycle ops and for divide-by-zero. The result is registered on the accept edge, so out_valid is high the cycle after accept (latency 1).
- IDLE -> BUSY: taken for MUL/MULHU/DIVU/REMU with a nonzero divisor.
  - Iteration counter loads XLEN-1 and decrements once per cycle.
  - Multiply: shift-add on a 2*XLEN product register.
  - Divide: restoring, one quotient bit per cycle.
  - At counter==0, BUSY -> DONE, with result/zero written on that same edge.
  - Accept edge to out_valid rising = XLEN+1 cycles (33 for XLEN=32).
- DONE: out_valid=1. result and zero are held stable until out_valid && out_ready, then -> IDLE.
  - in_ready is 0 in DONE; there is no accept on the release cycle.
- Divide by zero:
  - DIVU -> all ones; REMU -> r1.
  - 1-cycle latency.
- busy = (state==BUSY).
- flush:
  - Any state -> IDLE on the next edge; result is discarded.
  - Takes priority over the handshake and over completion in the same cycle.
  - in_ready is still 1 when flush coincides with in_valid in IDLE, but the request is dropped.
- Reset (rst_n low at an edge), from any state including mid-BUSY:
  - state=IDLE, out_valid=0, result=0, zero=1, busy=0, counter=0.
  - in_ready is 1 from the first cycle after reset.
- Operand inputs change while BUSY: no effect, because the latched copies are used.

Optional Feature:
- Macro: SEQ_ALU_MULDIV_EN.
- Defined: the multiply/divide opcodes behave as above, with the BUSY state and iterative datapath present.
- Undefined:
  - The BUSY state, counter and product/quotient registers are not generated.
  - Opcodes 1001/1010/1011/1110 are treated as reserved: result 0, zero=1, latency 1.
  - busy is tied 0.

Decomposition:
- Package seq_alu_pkg holds:
  - the OPW localparam;
  - named opcode constants (OP_AND ... OP_REMU);
  - the state enum (ST_IDLE, ST_BUSY, ST_DONE);
  - the is_multicycle(op) function.
- Sub-module seq_alu_muldiv: the iterative multiply/divide engine.
  - Handshake: start/op/a/b in, done/res out.
  - Instantiated only under SEQ_ALU_MULDIV_EN.
- The top level holds the FSM, the single-cycle combinational ops and the output registers.

Test Plan:
- Reset, then ADD r1=5, r2=7 with out_ready=1 -> out_valid 1 cycle after accept, result=12, zero=0. Then SUB 9,9 -> result=0, zero=1.
- SLT r1=0xFFFFFFFF, r2=1 -> result 1; SLTU with the same operands -> result 0. SRA 0x80000000 by 4 -> 0xF8000000; SLL by 33 uses shamt=1.
- MUL 0x10000, 0x10000 -> out_valid exactly 33 cycles after accept, result 0; MULHU with the same operands -> 1. in_ready=0 and busy=1 throughout.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU by 0 -> 0xFFFFFFFF in 1 cycle; REMU 100/0 -> 100.
- Backpressure: hold out_ready=0 for 5 cycles after completion -> result/zero stable, in_ready=0, no new accept. Release -> IDLE, and a new op is accepted the following cycle.
- Mid-operation events:
  - Assert flush 10 cycles into a DIVU -> IDLE next cycle, with no out_valid pulse.
  - Assert rst_n=0 mid-MUL -> out_valid=0, result=0, zero=1.
  - Build without SEQ_ALU_MULDIV_EN: MUL -> result 0 in 1 cycle.
